// File: rtl/mems_pkg.sv
// Shared encodings for the MEMS DAC sequencer: command/address fields, FSM states and the
// 24-bit command frame builder.
package mems_pkg;

    localparam logic [2:0] CMD_WR_IN  = 3'b000;
    localparam logic [2:0] CMD_UPD    = 3'b001;
    localparam logic [2:0] CMD_WR_UPD = 3'b011;
    localparam logic [2:0] CMD_RST    = 3'b101;
    localparam logic [2:0] CMD_REF    = 3'b111;

    localparam logic [2:0] ADDR_A   = 3'b000;
    localparam logic [2:0] ADDR_B   = 3'b001;
    localparam logic [2:0] ADDR_ALL = 3'b111;

    typedef enum logic [2:0] {
        StInit0,
        StInit1,
        StArb,
        StStart,
        StWaitHi,
        StWaitLo
    } state_e;

    // Which kind of word is in flight, so completion knows where to return.
    typedef enum logic [1:0] {
        PhInit0,
        PhInit1,
        PhRun
    } phase_e;

    function automatic logic [23:0] mems_frame(input logic [2:0]  cmd,
                                               input logic [2:0]  addr,
                                               input logic [15:0] data);
        return {2'b00, cmd, addr, data};
    endfunction

endpackage

// File: rtl/mems_rr_arb2.sv
// Two-way round-robin arbiter; req[0]=X, req[1]=Y, last_grant 0=X / 1=Y. Purely combinational.
module mems_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (en) begin
            unique case (req)
                2'b00: grant = 2'b00;
                2'b01: grant = 2'b01;
                2'b10: grant = 2'b10;
                2'b11: grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/mems_dac_sequencer.sv
// Sequences DAC init words, then round-robin X/Y channel writes onto a start/busy SPI master.
// Build option MEMS_SYNC_UPDATE_EN: write input registers only and issue update-all per X+Y pair.
module mems_dac_sequencer
    import mems_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned BUSY_TO = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x_req,
    input  logic [DATA_W-1:0] x_data,
    output logic              x_ack,
    input  logic              y_req,
    input  logic [DATA_W-1:0] y_data,
    output logic              y_ack,
    output logic [23:0]       spi_data,
    output logic              spi_start,
    input  logic              spi_busy,
    output logic              init_done,
    output logic              err
);

    localparam int unsigned      CNT_W    = $clog2(BUSY_TO);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TO - 1);

`ifdef MEMS_SYNC_UPDATE_EN
    localparam logic [2:0] CH_CMD = CMD_WR_IN;
`else
    localparam logic [2:0] CH_CMD = CMD_WR_UPD;
`endif

    state_e           state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [23:0]      spi_data_q, spi_data_d;
    logic             last_grant_q, last_grant_d;
    logic             init_done_q, init_done_d;
    logic             err_q, err_d;
    logic             arb_en, word_done;
    logic [1:0]       grant;

`ifdef MEMS_SYNC_UPDATE_EN
    logic pend_x_q, pend_x_d, pend_y_q, pend_y_d;
`endif

    mems_rr_arb2 u_arb (
        .req        ({y_req, x_req}),
        .last_grant (last_grant_q),
        .en         (arb_en),
        .grant      (grant)
    );

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        spi_data_d   = spi_data_q;
        last_grant_d = last_grant_q;
        init_done_d  = init_done_q;
        err_d        = err_q;
        arb_en       = 1'b0;
        word_done    = 1'b0;
        x_ack        = 1'b0;
        y_ack        = 1'b0;
        spi_start    = 1'b0;
`ifdef MEMS_SYNC_UPDATE_EN
        pend_x_d     = pend_x_q;
        pend_y_d     = pend_y_q;
`endif
        unique case (state_q)
            // The SPI master may still be finishing a word from before reset.
            StInit0, StInit1: begin
                if (!spi_busy) begin
                    spi_data_d = (state_q == StInit0) ? mems_frame(CMD_RST, ADDR_ALL, 16'h0001)
                                                      : mems_frame(CMD_REF, ADDR_ALL, 16'h0001);
                    phase_d    = (state_q == StInit0) ? PhInit0 : PhInit1;
                    state_d    = StStart;
                end
            end
            StArb: begin
                if (!spi_busy) begin
`ifdef MEMS_SYNC_UPDATE_EN
                    if (pend_x_q && pend_y_q) begin
                        spi_data_d = mems_frame(CMD_UPD, ADDR_ALL, 16'h0000);
                        pend_x_d   = 1'b0;
                        pend_y_d   = 1'b0;
                        state_d    = StStart;
                    end else begin
                        arb_en = 1'b1;
                    end
`else
                    arb_en = 1'b1;
`endif
                end
                if (grant[0]) begin
                    x_ack        = 1'b1;
                    spi_data_d   = mems_frame(CH_CMD, ADDR_A, x_data);
                    last_grant_d = 1'b0;
                    state_d      = StStart;
`ifdef MEMS_SYNC_UPDATE_EN
                    pend_x_d     = 1'b1;
`endif
                end else if (grant[1]) begin
                    y_ack        = 1'b1;
                    spi_data_d   = mems_frame(CH_CMD, ADDR_B, y_data);
                    last_grant_d = 1'b1;
                    state_d      = StStart;
`ifdef MEMS_SYNC_UPDATE_EN
                    pend_y_d     = 1'b1;
`endif
                end
            end
            StStart: begin
                spi_start = 1'b1;
                cnt_d     = '0;
                state_d   = StWaitHi;
            end
            StWaitHi: begin
                if (spi_busy) begin
                    state_d = StWaitLo;
                end else if (cnt_q == CNT_LAST) begin
                    err_d     = 1'b1;
                    word_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWaitLo: begin
                if (!spi_busy) word_done = 1'b1;
            end
            default: state_d = StInit0;
        endcase

        // Completed and timed-out words leave the same way, so init always finishes.
        if (word_done) begin
            unique case (phase_q)
                PhInit0: state_d = StInit1;
                PhInit1: begin
                    state_d     = StArb;
                    phase_d     = PhRun;
                    init_done_d = 1'b1;
                end
                default: state_d = StArb;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StInit0;
            phase_q      <= PhInit0;
            cnt_q        <= '0;
            spi_data_q   <= '0;
            last_grant_q <= 1'b1;
            init_done_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            spi_data_q   <= spi_data_d;
            last_grant_q <= last_grant_d;
            init_done_q  <= init_done_d;
            err_q        <= err_d;
        end
    end

`ifdef MEMS_SYNC_UPDATE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_x_q <= 1'b0;
            pend_y_q <= 1'b0;
        end else begin
            pend_x_q <= pend_x_d;
            pend_y_q <= pend_y_d;
        end
    end
`endif

    assign spi_data  = spi_data_q;
    assign init_done = init_done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mems_dac_sequencer.sv
// Bench for mems_dac_sequencer: transaction-level word/ack model, SPI master model, random requesters.
module tb_mems_dac_sequencer;

    localparam int BUSY_TO = 64;
    localparam logic [2:0] A_X = 3'b000, A_Y = 3'b001, A_ALL = 3'b111;
`ifdef MEMS_SYNC_UPDATE_EN
    localparam logic [2:0] CH_CMD = 3'b000;
`else
    localparam logic [2:0] CH_CMD = 3'b011;
`endif

    logic        clk, rst;
    logic        x_req, y_req, x_ack, y_ack;
    logic [15:0] x_data, y_data;
    logic [23:0] spi_data;
    logic        spi_start, spi_busy, init_done, err;

    mems_dac_sequencer #(.DATA_W(16), .BUSY_TO(BUSY_TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .x_req     (x_req),
        .x_data    (x_data),
        .x_ack     (x_ack),
        .y_req     (y_req),
        .y_data    (y_data),
        .y_ack     (y_ack),
        .spi_data  (spi_data),
        .spi_start (spi_start),
        .spi_busy  (spi_busy),
        .init_done (init_done),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state
    logic [23:0] exp_q[$];
    logic [23:0] start_log[$];
    bit          ack_log[$];
    logic [23:0] cur_word, w;
    bit          xfer_open, seen_hi, err_exp, init_done_exp, err_pend, done_pend;
    bit          last_y, pend_x, pend_y, gy, legal;
    bit          prev_ack, prev_start, prev_busy;
    bit          rst_prev = 1'b1;
    int          start_cyc, words_done;

    // SPI master model knobs
    bit spi_mute = 1'b0;
    bit rnd      = 1'b0;
    int spi_dly  = 2;
    int spi_len  = 30;
    int sm_d, sm_l;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] word(input logic [2:0] cmd, input logic [2:0] addr,
                                         input logic [15:0] d);
        return {2'b00, cmd, addr, d};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back(word(3'b101, A_ALL, 16'h0001));
        exp_q.push_back(word(3'b111, A_ALL, 16'h0001));
        xfer_open = 0; seen_hi = 0; cur_word = '0;
        err_exp = 0; init_done_exp = 0; err_pend = 0; done_pend = 0;
        words_done = 0; last_y = 1; pend_x = 0; pend_y = 0;
    endtask

    task automatic close_word(input bit timeout);
        xfer_open = 0;
        words_done++;
        if (timeout) err_pend = 1;
        if (words_done == 2) done_pend = 1;
    endtask

    // Single compare process: every cycle checks the DUT against the transaction model.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_prev) begin
                chk("rst_spi_start", 32'(spi_start), 0);
                chk("rst_spi_data", 32'(spi_data), 0);
                chk("rst_acks", 32'({x_ack, y_ack}), 0);
                chk("rst_init_done", 32'(init_done), 0);
                chk("rst_err", 32'(err), 0);
                model_reset();
            end else begin
                if (err_pend) begin err_exp = 1; err_pend = 0; end
                if (done_pend) begin init_done_exp = 1; done_pend = 0; end
                chk("err", 32'(err), 32'(err_exp));
                chk("init_done", 32'(init_done), 32'(init_done_exp));
                if (x_ack || y_ack) begin
                    chk("ack_onehot", 32'(x_ack & y_ack), 0);
                    gy    = y_ack;
                    legal = init_done_exp && !xfer_open && (exp_q.size() == 0) && !spi_busy
                            && (gy ? y_req : x_req);
                    chk("ack_legal", 32'(legal), 1);
                    if (x_req && y_req) chk("rr_alternate", 32'(gy), 32'(!last_y));
                    exp_q.push_back(word(CH_CMD, gy ? A_Y : A_X, gy ? y_data : x_data));
                    ack_log.push_back(gy);
                    last_y = gy;
`ifdef MEMS_SYNC_UPDATE_EN
                    if (gy) pend_y = 1; else pend_x = 1;
                    if (pend_x && pend_y) begin
                        exp_q.push_back(word(3'b001, A_ALL, 16'h0000));
                        pend_x = 0; pend_y = 0;
                    end
`endif
                end
                if (prev_ack) chk("ack_to_start", 32'(spi_start), 1);
                if (spi_start) begin
                    chk("start_single", 32'(prev_start), 0);
                    chk("start_after_busy_low", 32'(prev_busy), 0);
                    chk("start_no_overlap", 32'(xfer_open), 0);
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL start_unexpected: got word 0x%0h, want no start", spi_data);
                        w = spi_data;
                    end else begin
                        w = exp_q.pop_front();
                    end
                    chk("start_word", 32'(spi_data), 32'(w));
                    start_log.push_back(spi_data);
                    xfer_open = 1; seen_hi = 0; start_cyc = cyc; cur_word = w;
                end else begin
                    chk("spi_data_hold", 32'(spi_data), 32'(cur_word));
                    if (xfer_open) begin
                        if (spi_busy) seen_hi = 1;
                        else if (seen_hi) close_word(0);
                        else if (cyc - start_cyc == BUSY_TO) close_word(1);
                    end
                end
            end
            prev_ack   = x_ack | y_ack;
            prev_start = spi_start;
            prev_busy  = spi_busy;
            rst_prev   = rst;
        end
    end

    // SPI master: raises busy some cycles after start, holds it, ignores rst.
    initial begin
        spi_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (spi_start && !spi_mute) begin
                sm_d = rnd ? int'($urandom_range(1, 4)) : spi_dly;
                sm_l = rnd ? int'($urandom_range(1, 8)) : spi_len;
                repeat (sm_d) @(posedge clk);
                #1 spi_busy = 1'b1;
                repeat (sm_l) @(posedge clk);
                #1 spi_busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input bit is_y, input logic [15:0] d, output int waited);
        tick();
        if (is_y) begin y_req = 1'b1; y_data = d; end
        else begin x_req = 1'b1; x_data = d; end
        waited = 0;
        @(negedge clk);
        while (!(is_y ? y_ack : x_ack) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) begin
            checks++; errors++;
            $display("FAIL req_served: got no ack after %0d cycles, want ack (y=%0d)", waited, is_y);
        end
        tick();
        if (is_y) y_req = 1'b0; else x_req = 1'b0;
    endtask

    task automatic requester(input bit is_y, input int n);
        int wt;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 6)) @(posedge clk);
            drive_req(is_y, 16'($urandom), wt);
        end
    endtask

    task automatic wait_init();
        int n = 0;
        while (!init_done && n < 3000) begin @(negedge clk); n++; end
        chk("init_done_reached", 32'(init_done), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((xfer_open || exp_q.size() != 0 || spi_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_idle", 32'(xfer_open || exp_q.size() != 0 || spi_busy), 0);
        @(negedge clk);
    endtask

    task automatic chk_log(input string name, input int idx, input logic [23:0] exp);
        if (idx < start_log.size()) chk(name, 32'(start_log[idx]), 32'(exp));
        else begin
            checks++; errors++;
            $display("FAIL %s: got no word #%0d, want 0x%0h", name, idx, exp);
        end
    endtask

    initial begin
        int base, n, wt;
        rst = 1'b1; x_req = 0; y_req = 0; x_data = '0; y_data = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Init sequence with busy 2 cycles after start for 30 cycles
        wait_init();
        chk_log("init_word0", 0, 24'h2F0001);
        chk_log("init_word1", 1, 24'h3F0001);
        chk("init_err", 32'(err), 0);
        wait_idle();

        // Both requesters held: X,Y,X,Y,... starting with X
        tick();
        x_req = 1; y_req = 1; x_data = 16'hAAAA; y_data = 16'h5555;
        base = ack_log.size(); n = 0;
        while (ack_log.size() < base + 6 && n < 3000) begin @(negedge clk); n++; end
        tick();
        x_req = 0; y_req = 0;
        chk("alt_ack_count", ack_log.size() - base, 6);
        for (int i = 0; i < 6; i++)
            if (base + i < ack_log.size()) chk("alt_grant", 32'(ack_log[base + i]), i % 2);
        wait_idle();

        // Single X write: ack same cycle, then channel word
        base = start_log.size();
        drive_req(1'b0, 16'h1234, wt);
        chk("x_ack_latency", wt, 0);
        wait_idle();
`ifdef MEMS_SYNC_UPDATE_EN
        chk_log("x_word", base, 24'h001234);
`else
        chk_log("x_word", base, 24'h181234);
`endif
        // Then Y write
        drive_req(1'b1, 16'h5678, wt);
        wait_idle();
`ifdef MEMS_SYNC_UPDATE_EN
        chk_log("y_word", base + 1, 24'h015678);
        chk_log("update_all_word", base + 2, 24'h0F0000);
`else
        chk_log("y_word", base + 1, 24'h195678);
`endif

        // Busy never rises: err after BUSY_TO cycles, block keeps serving
        spi_mute = 1;
        drive_req(1'b0, 16'hBEEF, wt);
        @(negedge clk);
        chk("timeout_start_seen", 32'(spi_start | prev_start), 1);
        n = 0;
        while (!err && n < 200) begin @(negedge clk); n++; end
        chk("err_latency", n, BUSY_TO + 1);
        spi_mute = 0;
        wait_idle();
        base = start_log.size();
        drive_req(1'b1, 16'h0042, wt);
        wait_idle();
`ifdef MEMS_SYNC_UPDATE_EN
        chk_log("after_timeout_word", base, 24'h010042);
        chk_log("after_timeout_upd", base + 1, 24'h0F0000);
`else
        chk_log("after_timeout_word", base, 24'h190042);
`endif
        chk("err_sticky", 32'(err), 1);

        // Random traffic with random SPI timing
        rnd = 1;
        fork
            requester(1'b0, 30);
            requester(1'b1, 30);
        join
        wait_idle();
        rnd = 0;

        // Reset during WAIT_LO: init replays once the master releases busy
        spi_dly = 2; spi_len = 30;
        drive_req(1'b0, 16'h7777, wt);
        n = 0;
        while (!spi_busy && n < 100) begin @(negedge clk); n++; end
        chk("busy_before_rst", 32'(spi_busy), 1);
        repeat (3) @(negedge clk);
        base = start_log.size();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_init();
        chk_log("replay_word0", base, 24'h2F0001);
        chk_log("replay_word1", base + 1, 24'h3F0001);
        chk("replay_err_cleared", 32'(err), 0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion, want finish before time limit");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
